alu_req_scheduler: RTL and testbench

// - Shares one combinational 8-bit ALU (16 ops via 4-bit select; A+B carry flag) between N_REQ requesters.
// - Round-robin arbitration, operand/op capture, and hold of ALU inputs for multi-cycle ops (mul/div).
// - Returns a tagged result over valid/ready. Sits between command sources and the ALU datapath.

---
 rtl/alu_req_sched_pkg.sv | 39 +++
 rtl/alu_req_sched_rr_arb.sv | 33 +++
 rtl/alu_req_scheduler.sv | 148 ++++++++++++++
 tb/tb_alu_req_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_sched_pkg.sv
// rtl/alu_req_sched_pkg.sv - ALU op codes, scheduler states and EXEC hold-count helper
package alu_req_sched_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_NOT = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_ROL = 4'b1010,
    OP_ROR = 4'b1011,
    OP_MIN = 4'b1100,
    OP_MAX = 4'b1101,
    OP_LT  = 4'b1110,
    OP_EQ  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  // Extra EXEC cycles the ALU inputs must be held before the result is sampled.
  function automatic logic [3:0] op_lat(input logic [3:0] op, input logic [3:0] mul_lat,
                                        input logic [3:0] div_lat);
    case (op)
      OP_MUL:  return mul_lat;
      OP_DIV:  return div_lat;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_req_sched_rr_arb.sv
// rtl/alu_req_sched_rr_arb.sv - combinational round-robin grant starting at rr_ptr
module alu_req_sched_rr_arb #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_any
);

  int              idx;
  logic [ID_W-1:0] idx_w;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(rr_ptr) + k) % N_REQ;
      idx_w = ID_W'(idx);
      if (!grant_any && req_valid[idx_w]) begin
        grant[idx_w] = 1'b1;
        grant_id     = idx_w;
        grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - round-robin scheduler sharing one ALU among N_REQ requesters
// ALU_REQ_SCHED_DIVZERO_EN: divide by zero skips EXEC and answers 8'hFF with rsp_err set.
module alu_req_scheduler
  import alu_req_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 3,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*4-1:0] req_op,
  input  logic [N_REQ*8-1:0] req_a,
  input  logic [N_REQ*8-1:0] req_b,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_sel,
  input  logic [7:0]         alu_out,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_data,
  output logic               rsp_carry,
  output logic               rsp_err
);

  sched_state_e    state, state_nxt;
  logic [ID_W-1:0] rr_ptr, id_q, grant_id;
  logic [N_REQ-1:0] grant;
  logic            grant_any, accept, skip_exec;
  logic [3:0]      op_q, cnt_q, sel_op;
  logic [7:0]      a_q, b_q, sel_a, sel_b, rsp_data_q;
  logic            rsp_carry_q;
  logic [3:0]      op_arr [N_REQ];
  logic [7:0]      a_arr  [N_REQ];
  logic [7:0]      b_arr  [N_REQ];

  alu_req_sched_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      op_arr[i] = req_op[i*4 +: 4];
      a_arr[i]  = req_a[i*8 +: 8];
      b_arr[i]  = req_b[i*8 +: 8];
    end
  end

  assign sel_op = op_arr[grant_id];
  assign sel_a  = a_arr[grant_id];
  assign sel_b  = b_arr[grant_id];
  assign accept = (state == ST_IDLE) && grant_any;

`ifdef ALU_REQ_SCHED_DIVZERO_EN
  assign skip_exec = (sel_op == OP_DIV) && (sel_b == 8'd0);
`else
  assign skip_exec = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = skip_exec ? ST_RESP : ST_EXEC;
      ST_EXEC: if (cnt_q == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: req_ready = grant;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= sel_op;
        a_q   <= sel_a;
        b_q   <= sel_b;
        id_q  <= grant_id;
        cnt_q <= op_lat(sel_op, 4'(MUL_LAT), 4'(DIV_LAT));
        if (skip_exec) begin
          rsp_data_q  <= 8'hFF;
          rsp_carry_q <= 1'b0;
        end
      end
      // ALU inputs come straight from the latched operands, so they stay put while counting.
      if (state == ST_EXEC) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          rsp_data_q  <= alu_out;
          rsp_carry_q <= (op_q == OP_ADD) && alu_carry;
        end
      end
      if (state == ST_RESP && rsp_ready)
        rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

`ifdef ALU_REQ_SCHED_DIVZERO_EN
  logic rsp_err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)      rsp_err_q <= 1'b0;
    else if (accept) rsp_err_q <= skip_exec;
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = op_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - transaction model plus directed vectors for alu_req_scheduler
module tb_alu_req_scheduler;

  localparam int N_REQ   = 2;
  localparam int MUL_LAT = 1;
  localparam int DIV_LAT = 3;
`ifdef ALU_REQ_SCHED_DIVZERO_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid, req_ready;
  logic [N_REQ*4-1:0] req_op;
  logic [N_REQ*8-1:0] req_a, req_b;
  logic [7:0]         alu_a, alu_b, alu_out, rsp_data;
  logic [3:0]         alu_sel;
  logic               alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_err;
  logic [0:0]         rsp_id;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (b == 8'd0) ? 8'hFF : a / b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~a;
      4'd8:  return a << b[2:0];
      4'd9:  return a >> b[2:0];
      4'd12: return (a < b) ? a : b;
      4'd13: return (a > b) ? a : b;
      4'd14: return {7'd0, a < b};
      4'd15: return {7'd0, a == b};
      default: return a;
    endcase
  endfunction

  function automatic logic carry_f(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8];
  endfunction

  assign alu_out   = alu_f(alu_sel, alu_a, alu_b);
  assign alu_carry = carry_f(alu_a, alu_b);

  alu_req_scheduler #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", nm);
  endtask

  // Transaction model: one op in flight, m_wait counts edges until the response shows.
  bit               m_busy = 1'b0, m_skip = 1'b0;
  int               m_wait = 0, m_ptr = 0, m_id = 0, exp_gid, mi;
  logic [3:0]       m_op = '0;
  logic [7:0]       m_a = '0, m_b = '0;
  logic [N_REQ-1:0] exp_grant;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_grant = '0;
      exp_gid   = -1;
      for (int k = 0; k < N_REQ; k++) begin
        mi = (m_ptr + k) % N_REQ;
        if (exp_gid < 0 && req_valid[mi]) begin
          exp_gid       = mi;
          exp_grant[mi] = 1'b1;
        end
      end
      chk("req_ready", req_ready, m_busy ? '0 : exp_grant);
      chk("rsp_valid", rsp_valid, m_busy && m_wait == 0);
      if (m_busy && m_wait == 0) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_skip ? 8'hFF : alu_f(m_op, m_a, m_b));
        chk("rsp_carry", rsp_carry, !m_skip && m_op == 4'd0 && carry_f(m_a, m_b));
        chk("rsp_err", rsp_err, m_skip);
      end
      if (m_busy && !m_skip) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_sel", alu_sel, m_op);
      end
      if (!rst_n) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end else if (m_busy) begin
        if (m_wait > 0) m_wait--;
        else if (rsp_ready) begin
          m_busy = 1'b0;
          m_ptr  = (m_id + 1) % N_REQ;
        end
      end else if (exp_gid >= 0) begin
        m_id   = exp_gid;
        m_op   = req_op[exp_gid*4 +: 4];
        m_a    = req_a[exp_gid*8 +: 8];
        m_b    = req_b[exp_gid*8 +: 8];
        m_skip = DZ && m_op == 4'd3 && m_b == 8'd0;
        m_wait = m_skip ? 0 : 1 + ((m_op == 4'd2) ? MUL_LAT : (m_op == 4'd3) ? DIV_LAT : 0);
        m_busy = 1'b1;
      end
    end
  end

  task automatic set_lane(input int r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[r*4 +: 4] = op;
    req_a[r*8 +: 8]  = a;
    req_b[r*8 +: 8]  = b;
  endtask

  task automatic do_issue(input int r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int acc);
    bit ok;
    set_lane(r, op, a, b);
    req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[r];
    end
    if (!ok) timeout("accept_wait");
    acc = edge_cnt + 1;
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, output int lat, output logic [7:0] d, output logic c,
                          output logic e, output int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    if (!ok) timeout("rsp_wait");
    lat = edge_cnt + 1 - acc;
    d   = rsp_data;
    c   = rsp_carry;
    e   = rsp_err;
    id  = int'(rsp_id);
  endtask

  task automatic release_rsp();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int         lane;
    logic [3:0] op;
    logic [7:0] a, b, exp;
  } vec_t;

  vec_t vecs [4];
  int   acc, lat, id, acc_n, rsp_n, nrsp;
  int   ids [8];
  logic [7:0] d;
  logic c, e;
  bit   took;

  initial begin
    vecs[0] = '{0, 4'd1, 8'h05, 8'h07, 8'hFE};
    vecs[1] = '{1, 4'd4, 8'hF0, 8'h3C, 8'h30};
    vecs[2] = '{0, 4'd6, 8'hAA, 8'hFF, 8'h55};
    vecs[3] = '{1, 4'd0, 8'h7F, 8'h01, 8'h80};

    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_req_ready", req_ready, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;

    set_lane(0, 4'd0, 8'hF0, 8'h20);
    set_lane(1, 4'd1, 8'h05, 8'h03);
    req_valid = 2'b11;
    @(negedge clk);
    chk("first_grant", req_ready, 2'b01);
    acc = edge_cnt + 1;
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(acc, lat, d, c, e, id);
    chk("add_lat", lat, 2);
    chk("add_data", d, 8'h10);
    chk("add_carry", c, 1'b1);
    chk("add_id", id, 0);
    release_rsp();

    rsp_ready = 1'b0;
    do_issue(1, 4'd2, 8'd12, 8'd11, acc);
    wait_rsp(acc, lat, d, c, e, id);
    chk("mul_lat", lat, 2 + MUL_LAT);
    chk("mul_data", d, 8'h84);
    chk("mul_id", id, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("mul_hold_valid", rsp_valid, 1'b1);
      chk("mul_hold_data", rsp_data, 8'h84);
      chk("mul_hold_alu_a", alu_a, 8'd12);
      chk("mul_hold_alu_b", alu_b, 8'd11);
      chk("mul_hold_alu_sel", alu_sel, 4'd2);
    end
    release_rsp();

    do_issue(0, 4'd3, 8'd9, 8'd0, acc);
    wait_rsp(acc, lat, d, c, e, id);
`ifdef ALU_REQ_SCHED_DIVZERO_EN
    chk("divz_lat", lat, 1);
    chk("divz_data", d, 8'hFF);
    chk("divz_err", e, 1'b1);
`else
    chk("divz_lat", lat, 2 + DIV_LAT);
    chk("divz_err", e, 1'b0);
`endif
    release_rsp();

    do_issue(1, 4'd3, 8'd200, 8'd7, acc);
    wait_rsp(acc, lat, d, c, e, id);
    chk("div_lat", lat, 2 + DIV_LAT);
    chk("div_data", d, 8'd28);
    chk("div_err", e, 1'b0);
    release_rsp();

    foreach (vecs[i]) begin
      do_issue(vecs[i].lane, vecs[i].op, vecs[i].a, vecs[i].b, acc);
      wait_rsp(acc, lat, d, c, e, id);
      chk("vec_data", d, vecs[i].exp);
      chk("vec_lat", lat, 2);
      release_rsp();
    end

    do_reset();
    set_lane(0, 4'd0, 8'h01, 8'h02);
    set_lane(1, 4'd1, 8'h09, 8'h04);
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    acc_n = 0; rsp_n = 0;
    for (int cyc = 0; cyc < 100 && rsp_n < 8; cyc++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ids[rsp_n] = int'(rsp_id);
        rsp_n++;
      end
      took = |(req_ready & req_valid);
      @(posedge clk); #1;
      if (took) begin
        acc_n++;
        req_a = req_a + 16'h1311;
        if (acc_n >= 8) req_valid = 2'b00;
      end
    end
    req_valid = 2'b00;
    chk("alt_count", rsp_n, 8);
    for (int i = 0; i < 8; i++) chk("alt_order", ids[i], i % 2);

    do_issue(0, 4'd5, 8'h0F, 8'h30, acc);
    wait_rsp(acc, lat, d, c, e, id);
    chk("or_data", d, 8'h3F);
    release_rsp();
    do_issue(1, 4'd3, 8'd50, 8'd3, acc);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("no_rsp_after_reset", nrsp, 0);
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    chk("post_reset_grant", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
